shake_padder: RTL and testbench

Word-serial SHAKE message padder, sitting between the message input stream and the absorb datapath, alongside the remaining-size counter. Forwards 64-bit message words into rate-sized blocks. Applies the SHAKE domain/pad10*1 padding: byte 0x1F after the last message byte, 0x80 OR-ed into the final byte of the block. Emits the extra all-pad words or all-pad block when needed, and flags block and message boundaries for the permutation controller.

---
 rtl/shake_padder.sv | 179 +++++++++++++++++
 tb/tb_shake_padder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/shake_padder.sv
// rtl/shake_padder.sv - word-serial SHAKE message padder (0x1F domain byte, pad10*1)
//
// Forwards 64-bit message words into rate-sized blocks, appends SHAKE padding
// and emits the extra all-pad words/block when the message leaves no room.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start, rate_words     begin a message (IDLE only); rate sampled and clamped
//   in_data/in_valid/in_last/in_bytes/in_ready
//                         message word stream; in_bytes is valid bytes of last word
//   out_data/out_valid/out_ready
//                         padded word stream (single output register)
//   out_block_end         word is the last word of its block
//   out_msg_end           word is the last word of the message
//   busy                  state != IDLE or an output word is still held
`timescale 1ns/1ps
module shake_padder #(
  parameter int W              = 64,
  parameter int MAX_RATE_WORDS = 21
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [4:0]   rate_words,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  input  logic         in_last,
  input  logic [3:0]   in_bytes,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_block_end,
  output logic         out_msg_end,
  output logic         busy
);

  localparam int NB = W / 8;
  localparam logic [4:0] MAX_RATE = 5'(MAX_RATE_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_PASS, S_PAD} state_e;

  state_e         state_q, state_d;
  logic [4:0]     rate_q, rate_d;
  logic [4:0]     idx_q, idx_d;
  logic           pad_pending_q, pad_pending_d;
  logic [W-1:0]   out_data_q, out_data_d;
  logic           out_valid_q, out_valid_d;
  logic           block_end_q, block_end_d;
  logic           msg_end_q, msg_end_d;

  logic           can_load;
  logic           idx_last;
  logic           load;
  logic           word_msg_end;
  logic [W-1:0]   word;
  logic [3:0]     n_eff;

  // The output register may take a new word when empty or being drained.
  assign can_load = !out_valid_q || out_ready;
  assign idx_last = (idx_q == rate_q - 5'd1);
  assign n_eff    = (in_bytes > 4'd8) ? 4'd8 : in_bytes;

  always_comb begin
    state_d       = state_q;
    rate_d        = rate_q;
    idx_d         = idx_q;
    pad_pending_d = pad_pending_q;
    out_data_d    = out_data_q;
    out_valid_d   = out_valid_q;
    block_end_d   = block_end_q;
    msg_end_d     = msg_end_q;
    in_ready      = 1'b0;
    load          = 1'b0;
    word_msg_end  = 1'b0;
    word          = '0;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          rate_d        = (rate_words == 5'd0 || rate_words > MAX_RATE) ? MAX_RATE : rate_words;
          idx_d         = 5'd0;
          pad_pending_d = 1'b0;
          state_d       = S_PASS;
        end
      end

      S_PASS: begin
        in_ready = can_load;
        if (in_valid && can_load) begin
          load = 1'b1;
          word = in_data;
          if (in_last) begin
            if (n_eff < 4'd8) begin
              // Keep bytes below n, place the domain byte at n, zero above.
              for (int b = 0; b < NB; b++) begin
                if (4'(b) == n_eff) begin
                  word[8*b +: 8] = 8'h1F;
                end else if (4'(b) > n_eff) begin
                  word[8*b +: 8] = 8'h00;
                end
              end
              if (idx_last) begin
                word[W-1]    = 1'b1;
                word_msg_end = 1'b1;
                state_d      = S_IDLE;
              end else begin
                pad_pending_d = 1'b0;
                state_d       = S_PAD;
              end
            end else begin
              // Full final word: the 0x1F byte still has to be emitted.
              pad_pending_d = 1'b1;
              state_d       = S_PAD;
            end
          end
        end
      end

      S_PAD: begin
        if (can_load) begin
          load          = 1'b1;
          pad_pending_d = 1'b0;
          if (pad_pending_q) begin
            word[7:0] = 8'h1F;
          end
          if (idx_last) begin
            word[W-1]    = 1'b1;
            word_msg_end = 1'b1;
            state_d      = S_IDLE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (load) begin
      out_data_d  = word;
      out_valid_d = 1'b1;
      block_end_d = idx_last;
      msg_end_d   = word_msg_end;
      idx_d       = idx_last ? 5'd0 : idx_q + 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      rate_q        <= MAX_RATE;
      idx_q         <= 5'd0;
      pad_pending_q <= 1'b0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      block_end_q   <= 1'b0;
      msg_end_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      rate_q        <= rate_d;
      idx_q         <= idx_d;
      pad_pending_q <= pad_pending_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      block_end_q   <= block_end_d;
      msg_end_q     <= msg_end_d;
    end
  end

  assign out_data      = out_data_q;
  assign out_valid     = out_valid_q;
  assign out_block_end = block_end_q;
  assign out_msg_end   = msg_end_q;
  assign busy          = (state_q != S_IDLE) || out_valid_q;

endmodule

// File: tb/tb_shake_padder.sv
// tb/tb_shake_padder.sv - scoreboard testbench for shake_padder
`timescale 1ns/1ps
module tb_shake_padder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  rate_words = 5'd0;
  logic [63:0] in_data = 64'd0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic [3:0]  in_bytes = 4'd0;
  logic        in_ready;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_block_end;
  logic        out_msg_end;
  logic        busy;

  logic [65:0] exp_q[$];
  logic [63:0] msg_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          out_cnt = 0;
  bit          rand_ready = 1'b0;
  bit          mon_en = 1'b1;
  bit          held_v = 1'b0;
  logic [63:0] held_d = 64'd0;

  always #5 clk = ~clk;

  shake_padder #(.W(64), .MAX_RATE_WORDS(21)) dut (
    .clk(clk), .rst(rst), .start(start), .rate_words(rate_words),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_bytes(in_bytes), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_block_end(out_block_end), .out_msg_end(out_msg_end), .busy(busy)
  );

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [63:0] d, input logic be, input logic me);
    exp_q.push_back({d, be, me});
  endtask

  // Independent byte-level model of SHAKE padding over msg_q.
  task automatic push_model(input int rate, input int nlast);
    logic [7:0]  bq[$];
    logic [63:0] d;
    int          nw;
    for (int i = 0; i < msg_q.size(); i++) begin
      int nb;
      nb = (i == msg_q.size() - 1) ? nlast : 8;
      for (int b = 0; b < nb; b++) bq.push_back(msg_q[i][8*b +: 8]);
    end
    bq.push_back(8'h1F);
    while (bq.size() % (8 * rate) != 0) bq.push_back(8'h00);
    bq[bq.size()-1] = bq[bq.size()-1] | 8'h80;
    nw = bq.size() / 8;
    for (int w = 0; w < nw; w++) begin
      for (int b = 0; b < 8; b++) d[8*b +: 8] = bq[8*w + b];
      push_exp(d, (w % rate) == rate - 1, w == nw - 1);
    end
  endtask

  // Output driver: random back-pressure when enabled.
  always @(posedge clk) begin
    #1;
    out_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
  end

  // Monitor: pops the scoreboard on every output handshake.
  always @(negedge clk) begin
    if (!rst && mon_en) begin
      if (held_v) check("hold", 72'({out_valid, out_data}), 72'({1'b1, held_d}));
      held_v = out_valid && !out_ready;
      held_d = out_data;
      if (out_valid && out_ready) begin
        out_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL extra_word: got %h expected none", out_data);
        end else begin
          check("word", 72'({out_data, out_block_end, out_msg_end}), 72'(exp_q.pop_front()));
        end
      end
    end else begin
      held_v = 1'b0;
    end
  end

  task automatic wait_idle(input string name, input int exp_cnt);
    int t;
    t = 0;
    while ((busy || exp_q.size() != 0) && t < 600) begin
      @(posedge clk); #1; t++;
    end
    check({name, "_drain"}, 72'(exp_q.size()), 72'(0));
    check({name, "_count"}, 72'(out_cnt), 72'(exp_cnt));
    exp_q.delete();
  endtask

  task automatic start_msg(input logic [4:0] r);
    int t;
    t = 0;
    while (busy && t < 600) begin
      @(posedge clk); #1; t++;
    end
    out_cnt = 0;
    start = 1'b1;
    rate_words = r;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_word(input logic [63:0] d, input logic last, input logic [3:0] nb);
    bit hs;
    int t;
    in_data = d; in_valid = 1'b1; in_last = last; in_bytes = nb;
    t = 0;
    do begin
      @(negedge clk); hs = in_ready;
      @(posedge clk); #1; t++;
    end while (!hs && t < 300);
    if (!hs) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: got in_ready=0 expected 1");
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_msg(input int nlast);
    for (int i = 0; i < msg_q.size(); i++) begin
      if (i == msg_q.size() - 1) send_word(msg_q[i], 1'b1, 4'(nlast));
      else                       send_word(msg_q[i], 1'b0, 4'd8);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 72'({out_valid, out_data, out_block_end, out_msg_end, in_ready, busy}), 72'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // Rate 21, 3-byte message.
    start_msg(5'd21);
    check("ready_after_start", 72'(in_ready), 72'(1));
    push_exp(64'h0000_0000_1FCC_BBAA, 1'b0, 1'b0);
    for (int i = 1; i < 20; i++) push_exp(64'd0, 1'b0, 1'b0);
    push_exp(64'h8000_0000_0000_0000, 1'b1, 1'b1);
    send_word(64'h1122_3344_55CC_BBAA, 1'b1, 4'd3);
    wait_idle("t1", 21);

    // Rate 17, exactly one full block: a whole pad block follows.
    start_msg(5'd17);
    for (int i = 0; i < 17; i++) push_exp(64'h0101_0101_0000_0000 * 64'(i + 1) + 64'(i), i == 16, 1'b0);
    push_exp(64'h0000_0000_0000_001F, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) push_exp(64'd0, 1'b0, 1'b0);
    push_exp(64'h8000_0000_0000_0000, 1'b1, 1'b1);
    for (int i = 0; i < 17; i++) send_word(64'h0101_0101_0000_0000 * 64'(i + 1) + 64'(i), i == 16, 4'd8);
    wait_idle("t2", 34);

    // Rate 17, 7-byte final word in last slot: 0x1F and 0x80 share byte 7.
    start_msg(5'd17);
    for (int i = 0; i < 16; i++) push_exp(64'hFEDC_BA98_7654_3210 ^ 64'(i), 1'b0, 1'b0);
    push_exp(64'h9FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) send_word(64'hFEDC_BA98_7654_3210 ^ 64'(i), 1'b0, 4'd8);
    send_word(64'h00FF_FFFF_FFFF_FFFF, 1'b1, 4'd7);
    wait_idle("t3", 17);

    // Empty message at rate 1.
    start_msg(5'd1);
    push_exp(64'h8000_0000_0000_001F, 1'b1, 1'b1);
    send_word(64'h0000_0000_0000_DEAD, 1'b1, 4'd0);
    wait_idle("t4", 1);

    // 40-word message at rate 21, first without stalls.
    msg_q.delete();
    for (int i = 0; i < 40; i++) msg_q.push_back({32'hA5A5_0000 | 32'(i), 32'(i) * 32'h0101_0101});
    start_msg(5'd21);
    push_model(21, 5);
    send_msg(5);
    wait_idle("t5a", 42);

    // Same message with random back-pressure; out-of-range rate clamps to 21.
    rand_ready = 1'b1;
    start_msg(5'd25);
    push_model(21, 5);
    send_msg(5);
    wait_idle("t5b", 42);
    rand_ready = 1'b0;

    // Reset in the middle of PAD, then a fresh message.
    mon_en = 1'b0;
    start_msg(5'd21);
    send_word(64'h0000_0000_0000_7777, 1'b1, 4'd2);
    repeat (4) @(posedge clk);
    #1;
    check("busy_in_pad", 72'(busy), 72'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    check("reset_mid_pad", 72'({out_valid, out_data, out_block_end, out_msg_end, in_ready, busy}), 72'(0));
    rst = 1'b0;
    exp_q.delete();
    mon_en = 1'b1;
    @(posedge clk); #1;
    start_msg(5'd21);
    push_exp(64'h0000_0000_0000_001F, 1'b0, 1'b0);
    for (int i = 1; i < 20; i++) push_exp(64'd0, 1'b0, 1'b0);
    push_exp(64'h8000_0000_0000_0000, 1'b1, 1'b1);
    send_word(64'h1234_5678_9ABC_DEF0, 1'b1, 4'd0);
    wait_idle("t6", 21);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
